// File: rtl/memcore_uram_arbiter.sv
// Round-robin arbiter sharing a dual-port memory between NUM_REQ requesters.
// Each cycle the two highest-priority valid requesters are granted, one per
// memory port. Read data comes back one cycle after the grant edge on a
// per-requester response channel.
//
// Ports:
//   clk, reset_n       clock (rising edge) and asynchronous active-low reset
//   enable             0 blocks new grants; responses already in flight still drain
//   req_valid/we       per-requester request valid and write flag
//   req_addr/req_data  packed per-requester address and write data (requester i at slice i)
//   req_ready          per-requester grant (combinational)
//   resp_valid         one-cycle read response pulse per requester
//   resp_data          packed per-requester read data, held until that requester's next read
//   mem_*0 / mem_*1    memory port 0 and port 1 drive, plus returned read data
module memcore_uram_arbiter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 6,
   parameter int unsigned NUM_REQ       = 4
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             enable,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               resp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data,
   output logic [ADDRESS_WIDTH-1:0]         mem_address0,
   output logic                             mem_ce0,
   output logic [DATA_WIDTH-1:0]            mem_d0,
   output logic                             mem_we0,
   input  logic [DATA_WIDTH-1:0]            mem_q0,
   output logic [ADDRESS_WIDTH-1:0]         mem_address1,
   output logic                             mem_ce1,
   output logic [DATA_WIDTH-1:0]            mem_d1,
   output logic                             mem_we1,
   input  logic [DATA_WIDTH-1:0]            mem_q1
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   // Outstanding read on one memory port: which requester gets the data.
   typedef struct packed {
      logic             valid;
      logic [PTR_W-1:0] idx;
   } tag_t;

   logic [ADDRESS_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0]    wdata_a [NUM_REQ];
   logic [DATA_WIDTH-1:0]    rdata_q [NUM_REQ];

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] rr_next_c;
   logic [PTR_W-1:0] cand0_c;
   logic [PTR_W-1:0] cand1_c;
   logic             found0_c;
   logic             found1_c;
   logic             clash_c;
   logic             go_c;
   logic             grant0_c;
   logic             grant1_c;
   int unsigned      scan_c;
   tag_t             tag0;
   tag_t             tag1;

   // Unpack per-requester buses into arrays.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_a[gi]  = req_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign wdata_a[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q[gi];
   end

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
      if (32'(i) == NUM_REQ - 1) return '0;
      return i + PTR_W'(1);
   endfunction

   // Walk requesters from rr_ptr downward in priority; pick the first two valid ones.
   always_comb begin : p_scan
      found0_c = 1'b0;
      found1_c = 1'b0;
      cand0_c  = '0;
      cand1_c  = '0;
      scan_c   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_c = 32'(rr_ptr) + k;
         if (scan_c >= NUM_REQ) scan_c = scan_c - NUM_REQ;
         if (req_valid[PTR_W'(scan_c)]) begin
            if (!found0_c) begin
               found0_c = 1'b1;
               cand0_c  = PTR_W'(scan_c);
            end else if (!found1_c) begin
               found1_c = 1'b1;
               cand1_c  = PTR_W'(scan_c);
            end
         end
      end
   end

   // Same address with a write on either side would race between the ports; port 1 yields.
   assign clash_c  = (addr_a[cand0_c] == addr_a[cand1_c]) && (req_we[cand0_c] || req_we[cand1_c]);
   assign go_c     = enable & reset_n;
   assign grant0_c = go_c & found0_c;
   assign grant1_c = go_c & found1_c & ~clash_c;

   always_comb begin : p_ready
      req_ready = '0;
      if (grant0_c) req_ready[cand0_c] = 1'b1;
      if (grant1_c) req_ready[cand1_c] = 1'b1;
   end

   assign mem_ce0      = grant0_c;
   assign mem_we0      = grant0_c & req_we[cand0_c];
   assign mem_address0 = grant0_c ? addr_a[cand0_c]  : '0;
   assign mem_d0       = grant0_c ? wdata_a[cand0_c] : '0;
   assign mem_ce1      = grant1_c;
   assign mem_we1      = grant1_c & req_we[cand1_c];
   assign mem_address1 = grant1_c ? addr_a[cand1_c]  : '0;
   assign mem_d1       = grant1_c ? wdata_a[cand1_c] : '0;

   // Next top priority goes to the requester just after the last one served.
   always_comb begin : p_rr_next
      rr_next_c = rr_ptr;
      if (grant1_c)      rr_next_c = wrap_inc(cand1_c);
      else if (grant0_c) rr_next_c = wrap_inc(cand0_c);
   end

   // Response pulse is the cycle in which mem_q carries the data for each tag.
   always_comb begin : p_resp_valid
      resp_valid = '0;
      if (tag0.valid) resp_valid[tag0.idx] = 1'b1;
      if (tag1.valid) resp_valid[tag1.idx] = 1'b1;
   end

   // Pointer, read tags and per-requester read data holding registers.
   always_ff @(posedge clk or negedge reset_n) begin : p_state
      if (!reset_n) begin
         rr_ptr <= '0;
         tag0   <= '0;
         tag1   <= '0;
         for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
      end else begin
         rr_ptr <= rr_next_c;
         tag0   <= '{valid: grant0_c & ~req_we[cand0_c], idx: cand0_c};
         tag1   <= '{valid: grant1_c & ~req_we[cand1_c], idx: cand1_c};
         if (tag0.valid) rdata_q[tag0.idx] <= mem_q0;
         if (tag1.valid) rdata_q[tag1.idx] <= mem_q1;
      end
   end

endmodule

// File: doc/memcore_uram_arbiter.md
MEMCORE_URAM_ARBITER -- requirements
Module: memcore_uram_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, the word width of the shared memory.
REQ-002 The block SHALL take parameter ADDRESS_WIDTH, default 6, the memory address width.
REQ-003 The block SHALL take parameter NUM_REQ, default 4, the number of requesters (legal range 2..8).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, no new grants are issued.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, combinational.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses; requester i at slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- resp_valid  out  NUM_REQ  one-cycle read-data valid pulse.
- resp_data  out  NUM_REQ*DATA_WIDTH  packed read data, registered.
- mem_address0 / mem_ce0 / mem_d0 / mem_we0  out  ADDRESS_WIDTH / 1 / DATA_WIDTH / 1  memory port 0 drive.
- mem_q0  in  DATA_WIDTH  memory port 0 read data, one cycle after ce0 with we0 = 0.
- mem_address1 / mem_ce1 / mem_d1 / mem_we1 / mem_q1  same as port 0, for port 1.

Function
REQ-005 The block SHALL hold a round-robin pointer rr_ptr (log2 NUM_REQ bits) naming the highest-priority requester; priority decreases modulo NUM_REQ from rr_ptr.
REQ-006 Each cycle with enable = 1 and reset_n = 1, the block SHALL grant the first valid requester in priority order to port 0 and the second valid requester to port 1.
REQ-007 The block SHALL NOT grant a requester to both ports in the same cycle, and SHALL grant at most one requester per port.
REQ-008 Address conflict: if both candidates have equal addresses and at least one is a write, the block SHALL grant only the port-0 candidate; the other requester waits.
REQ-009 req_ready[i] SHALL be 1 exactly when requester i is granted; a transfer occurs when req_valid[i] and req_ready[i] are both 1 on a rising edge.
REQ-010 For a granted port p, the block SHALL drive mem_ce_p = 1, mem_we_p = req_we, mem_address_p = req_addr slice, and mem_d_p = req_data slice, all combinationally. An ungranted port SHALL drive ce = 0, we = 0, and address/data = 0.
REQ-011 On a granted read, the block SHALL register a tag (valid, requester index) per port. On the next cycle, it SHALL pulse resp_valid[index] for exactly one cycle and load resp_data[index] from mem_q_p.
REQ-012 resp_data slices SHALL hold their last loaded value until the next read response for the same requester; writes SHALL produce no response.
REQ-013 Read latency SHALL be exactly 1 cycle from the grant edge to the resp_valid cycle, with no backpressure on responses.
REQ-014 If one requester receives responses in back-to-back cycles, both SHALL be delivered without loss.
REQ-015 rr_ptr update:
- If any grant occurred, rr_ptr SHALL become (index of the lowest-priority granted requester + 1) mod NUM_REQ.
- If no grant occurred, rr_ptr SHALL be unchanged.
REQ-016 With enable = 0, the block SHALL force all req_ready and mem_ce to 0. Responses for reads granted in the previous cycle SHALL still be delivered.
REQ-017 With a single valid requester, the block SHALL grant it to port 0 and leave port 1 idle.

Reset
REQ-018 While reset_n = 0, the block SHALL force rr_ptr = 0, both tags invalid, resp_valid = 0, resp_data = 0, and all req_ready, mem_ce and mem_we to 0, asynchronously.
REQ-019 If reset asserts while a read is in flight, the block SHALL discard it; no resp_valid pulse SHALL follow deassertion.
REQ-020 After reset_n rises, the first grant cycle SHALL use requester 0 as highest priority.

Verification
REQ-021 Single read: req_valid = 0001, req_we = 0, addr0 = 5, mem[5] = 0xA5A5 -> cycle 0: ready = 0001, ce0 = 1, ce1 = 0; cycle 1: resp_valid = 0001, resp_data[0] = 0xA5A5.
REQ-022 Fairness: all four requesters hold reads for 4 cycles from reset -> grants in pairs {0,1}, {2,3}, {0,1}, {2,3}, and each requester receives exactly 2 responses.
REQ-023 Conflict: requester 0 writes addr 3 and requester 1 reads addr 3 in the same cycle, rr_ptr = 0 -> only requester 0 is granted. Requester 1 is granted the next cycle and reads the new data.
REQ-024 Enable gating: enable drops in the cycle after a two-read grant -> both resp_valid pulses still occur, no ce asserts, and rr_ptr is unchanged while enable = 0.
REQ-025 Reset mid-flight: reset_n falls in the grant cycle of a read -> resp_valid stays 0 and all outputs are 0. After release, requester 0 holds top priority.
